// File: rtl/contador_estacionamiento.sv
// Parking-occupancy counter: edge-detects raw entry/exit sensor levels and keeps
// a saturating occupancy count with capacity flags and rejected-event alarms.
module contador_estacionamiento #(
  parameter int unsigned W         = 8,
  parameter int unsigned CAPACIDAD = 7,
  parameter int unsigned UMBRAL    = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entrada,
  input  logic         salida,
  output logic [W-1:0] autos,
  output logic [W-1:0] libres,
  output logic         lleno,
  output logic         vacio,
  output logic         casi_lleno,
  output logic         alarma_entrada,
  output logic         alarma_salida
);

  if (CAPACIDAD > (2 ** W) - 1 || UMBRAL > CAPACIDAD || UMBRAL == 0) begin : g_param_check
    $error("contador_estacionamiento: need 0 < UMBRAL <= CAPACIDAD <= 2^W-1");
  end

  localparam logic [W-1:0] CAP = W'(CAPACIDAD);
  localparam logic [W-1:0] UMB = W'(UMBRAL);

  logic         ent_q, sal_q;
  logic         ev_in, ev_out;
  logic [W-1:0] autos_q, autos_d;
  logic         al_ent_d, al_sal_d;

  assign ev_in  = entrada & ~ent_q;
  assign ev_out = salida  & ~sal_q;

  always_comb begin
    autos_d  = autos_q;
    al_ent_d = 1'b0;
    al_sal_d = 1'b0;
    unique case ({ev_in, ev_out})
      2'b10: begin
        if (autos_q < CAP) autos_d = autos_q + W'(1);
        else               al_ent_d = 1'b1;
      end
      2'b01: begin
        if (autos_q != '0) autos_d = autos_q - W'(1);
        else               al_sal_d = 1'b1;
      end
      2'b11: begin
        // An empty lot cannot release a car, but the arriving one still enters.
        if (autos_q == '0) begin
          autos_d  = W'(1);
          al_sal_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Edge registers track the sensors even in reset so a held sensor is not an event.
  always_ff @(posedge clk) begin
    ent_q <= entrada;
    sal_q <= salida;
    if (rst) begin
      autos_q        <= '0;
      alarma_entrada <= 1'b0;
      alarma_salida  <= 1'b0;
    end else begin
      autos_q        <= autos_d;
      alarma_entrada <= al_ent_d;
      alarma_salida  <= al_sal_d;
    end
  end

  assign autos      = autos_q;
  assign libres     = CAP - autos_q;
  assign lleno      = (autos_q == CAP);
  assign vacio      = (autos_q == '0);
  assign casi_lleno = (autos_q >= UMB);

endmodule

// File: tb/tb_contador_estacionamiento.sv
// Bench for contador_estacionamiento: two configurations (7/6 and 12/10 on W=4)
// driven by shared stimulus, checked against vector tables and a counting model.
module tb_contador_estacionamiento;

  logic clk = 1'b0;
  logic rst, entrada, salida;

  logic [7:0] autos_a, libres_a;
  logic       lleno_a, vacio_a, casi_a, ae_a, as_a;
  logic [3:0] autos_b, libres_b;
  logic       lleno_b, vacio_b, casi_b, ae_b, as_b;

  always #5 clk = ~clk;

  contador_estacionamiento #(.W(8), .CAPACIDAD(7), .UMBRAL(6)) dut_a (
    .clk(clk), .rst(rst), .entrada(entrada), .salida(salida),
    .autos(autos_a), .libres(libres_a), .lleno(lleno_a), .vacio(vacio_a),
    .casi_lleno(casi_a), .alarma_entrada(ae_a), .alarma_salida(as_a)
  );

  contador_estacionamiento #(.W(4), .CAPACIDAD(12), .UMBRAL(10)) dut_b (
    .clk(clk), .rst(rst), .entrada(entrada), .salida(salida),
    .autos(autos_b), .libres(libres_b), .lleno(lleno_b), .vacio(vacio_b),
    .casi_lleno(casi_b), .alarma_entrada(ae_b), .alarma_salida(as_b)
  );

  typedef struct {
    bit e, s, r;
    int autos;
    bit al_e, al_s;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, index 0 = config A, 1 = config B.
  int caps[2] = '{7, 12};
  int umbs[2] = '{6, 10};
  int m_cnt[2];
  bit m_ae[2], m_as[2];
  bit prev_e, prev_s;

  function automatic int pack(int n, int lib, bit ll, bit va, bit ca, bit ae, bit as_);
    return (n << 16) | (lib << 8) | (int'(ll) << 4) | (int'(va) << 3) |
           (int'(ca) << 2) | (int'(ae) << 1) | int'(as_);
  endfunction

  function automatic int expect_vec(int cap, int umb, int n, bit ae, bit as_);
    return pack(n, cap - n, n == cap, n == 0, n >= umb, ae, as_);
  endfunction

  function automatic int act_a();
    return pack(int'(autos_a), int'(libres_a), lleno_a, vacio_a, casi_a, ae_a, as_a);
  endfunction

  function automatic int act_b();
    return pack(int'(autos_b), int'(libres_b), lleno_b, vacio_b, casi_b, ae_b, as_b);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %06h need %06h (autos<<16|libres<<8|ll,va,ca,ae,as)",
               name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, sample after it.
  task automatic cycle(bit e, bit s, bit r);
    bit ev_i, ev_o;
    entrada = e; salida = s; rst = r;
    @(posedge clk);
    ev_i = e && !prev_e;
    ev_o = s && !prev_s;
    prev_e = e;
    prev_s = s;
    for (int i = 0; i < 2; i++) begin
      m_ae[i] = 1'b0;
      m_as[i] = 1'b0;
      if (r) m_cnt[i] = 0;
      else if (ev_i && ev_o) begin
        if (m_cnt[i] == 0) begin m_cnt[i] = 1; m_as[i] = 1'b1; end
      end else if (ev_i) begin
        if (m_cnt[i] == caps[i]) m_ae[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (ev_o) begin
        if (m_cnt[i] == 0) m_as[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, "_a"}, act_a(), expect_vec(caps[0], umbs[0], m_cnt[0], m_ae[0], m_as[0]));
    check({tag, "_b"}, act_b(), expect_vec(caps[1], umbs[1], m_cnt[1], m_ae[1], m_as[1]));
  endtask

  function automatic void add(bit e, bit s, bit r, int n, bit ae, bit as_);
    vec_t v;
    v.e = e; v.s = s; v.r = r; v.autos = n; v.al_e = ae; v.al_s = as_;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; entrada = 1'b0; salida = 1'b0;
    prev_e = 1'b0; prev_s = 1'b0;
    m_cnt = '{0, 0}; m_ae = '{0, 0}; m_as = '{0, 0};

    // Reset with entry held high, then held 5 more cycles: no event.
    add(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // One 1-cycle pulse and two 4-cycle pulses.
    add(1, 0, 0, 1, 0, 0); add(0, 0, 0, 1, 0, 0);
    for (int p = 2; p <= 3; p++) begin
      for (int i = 0; i < 4; i++) add(1, 0, 0, p, 0, 0);
      add(0, 0, 0, p, 0, 0);
    end
    // Simultaneous at 3, then to 4 and reset during an entry rise.
    add(1, 1, 0, 3, 0, 0); add(0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 4, 0, 0); add(0, 0, 0, 4, 0, 0);
    add(1, 0, 1, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0); add(0, 0, 0, 1, 0, 0);
    // Exit to empty, exit rejected, then simultaneous from empty.
    add(0, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1); add(0, 0, 0, 1, 0, 0);
    // Fill to capacity, rejected eighth, simultaneous while full.
    for (int k = 2; k <= 7; k++) begin add(1, 0, 0, k, 0, 0); add(0, 0, 0, k, 0, 0); end
    add(1, 0, 0, 7, 1, 0); add(1, 0, 0, 7, 0, 0); add(0, 0, 0, 7, 0, 0);
    add(1, 1, 0, 7, 0, 0); add(0, 0, 0, 7, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].e, tbl[i].s, tbl[i].r);
      check($sformatf("tbl%0d", i), act_a(),
            expect_vec(7, 6, tbl[i].autos, tbl[i].al_e, tbl[i].al_s));
      check_model($sformatf("tblm%0d", i));
    end

    // Saturation of the 12/10 configuration on a 4-bit counter.
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    check("sat_rst_b", act_b(), expect_vec(12, 10, 0, 0, 0));
    for (int k = 1; k <= 13; k++) begin
      cycle(1, 0, 0);
      check($sformatf("sat_b%0d", k), act_b(),
            expect_vec(12, 10, (k > 12) ? 12 : k, k == 13, 0));
      check_model($sformatf("satm%0d", k));
      cycle(0, 0, 0);
      check($sformatf("sat_hold_b%0d", k), act_b(),
            expect_vec(12, 10, (k > 12) ? 12 : k, 0, 0));
    end

    // Random sensor levels: entry-biased, then exit-biased, rare resets.
    for (int i = 0; i < 800; i++) begin
      bit e, s, r;
      r = ($urandom_range(0, 79) == 0);
      if (i < 400) begin
        e = ($urandom_range(0, 2) != 0);
        s = ($urandom_range(0, 3) == 0);
      end else begin
        e = ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 2) != 0);
      end
      cycle(e, s, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
